rlo_stack_unit: RTL and testbench
=================================

// Module: rlo_stack_unit
// PURPOSE
//  Parametrised successor to the single-bit RLO register. Multi-source bit-logic accumulator for the PLC core:
//  - computes the RLO from a NUM_SRC-wide operand bus;
//  - tracks the first-check (FC) flag;
//  - provides a nesting stack for bracketed logic (A( / O( / X( ... )).
//  Sits between operand fetch (RAM/regs/LU/comparator/semaphore bits) and the conditional jump/assign logic.
// PARAMETERS
//  NUM_SRC      8   operand bits on RLO_Src; SEL_W = $clog2(NUM_SRC)
//  STACK_DEPTH  7   max bracket nesting levels (>=1); PTR_W = $clog2(STACK_DEPTH+1)
// PORTS
//  CLK           in   1        system clock, rising edge
//  CPU_Reset_n   in   1        asynchronous, active-low reset
//  RLO_EN        in   1        execute RLO_OPCode this cycle
//  RLO_OPCode    in   5        operation, see BEHAVIOUR
//  RLO_SrcSel    in   SEL_W    operand index into RLO_Src (also edge-memory slot)
//  RLO_Src       in   NUM_SRC  operand bits
//  RLO_ErrClr    in   1        clear sticky stack error flags
//  RLO           out  1        result of logic operation
//  RLO_FC        out  1        1 = next logic op is a first check (acts as load)
//  RLO_Depth     out  PTR_W    current bracket nesting depth
//  RLO_StkOvf    out  1        sticky: push attempted with stack full
//  RLO_StkUnf    out  1        sticky: pop attempted with stack empty
// BEHAVIOUR
//  - Reset (async, CPU_Reset_n=0): RLO=0, RLO_FC=1, RLO_Depth=0, RLO_StkOvf=0, RLO_StkUnf=0, stack/edge memory cleared.
//  - All outputs registered; an op with RLO_EN=1 at edge k is visible after edge k. RLO_EN=0: full state hold.
//  - s = RLO_Src[RLO_SrcSel]; SrcSel >= NUM_SRC reads s=0.
//  - Opcodes (FC' = new FC):
//    00 LD   RLO<=s, FC'=0;  01 LDN RLO<=~s, FC'=0
//    02 A / 03 AN   RLO <= FC ? s / ~s : RLO & s / RLO & ~s;   FC'=0
//    04 O / 05 ON   RLO <= FC ? s / ~s : RLO | s / RLO | ~s;   FC'=0
//    06 X / 07 XN   RLO <= FC ? s / ~s : RLO ^ s / ~(RLO ^ s); FC'=0
//    08 NOT  RLO<=~RLO, FC unchanged
//    09 SET  RLO<=1, FC'=0;  0A CLR RLO<=0, FC'=0
//    0B END  FC'=1, RLO unchanged (network boundary)
//    0C A( / 0D O( / 0E X(
//       push {RLO, FC, op} with op = AND/OR/XOR; Depth+1; FC'=1; RLO unchanged
//    0F )  pop {r, f, op}; Depth-1; FC'=0
//       f=1 -> RLO unchanged (inner result is a first check)
//       f=0 -> RLO <= op(r, RLO)
//    10 FP / 11 FN  edge ops, only with RLO_EDGE_EN; else NOP
//    12..1F  NOP, no state change
//  - Stack full (Depth==STACK_DEPTH) + push: no push, RLO/FC/Depth unchanged, RLO_StkOvf<=1.
//  - Stack empty + pop: RLO/FC/Depth unchanged, RLO_StkUnf<=1.
//  - RLO_ErrClr clears both flags next edge; a same-cycle error event wins (flag stays 1).
//  - Flags never affect normal ops; a program may continue after an error.
//  - Reset mid-bracket discards all stack content; no partial pop.
// CONFIGURATION
//  RLO_EDGE_EN defined:
//    - adds NUM_SRC-bit edge memory M, reset 0, indexed by RLO_SrcSel (index >= NUM_SRC -> NOP)
//    - FP: RLO <= RLO & ~M[i]
//    - FN: RLO <= ~RLO & M[i]
//    - both: M[i] <= RLO (pre-op value); FC'=0
//  Undefined: no memory instantiated, 10/11 are NOPs.
// STRUCTURE
//  rlo_pkg:
//    - opcode localparams (RLO_OP_LD..RLO_OP_FN)
//    - bracket-op encoding (BR_AND/BR_OR/BR_XOR, 2 bits)
//    - typedef rlo_stk_entry_t {rlo, fc, op[1:0]}
//  Sub-module rlo_stack: STACK_DEPTH-deep LIFO of rlo_stk_entry_t
//    - ports push/pop/full/empty/depth
//    - push and pop never asserted together
// TESTING
//  1 Reset: CPU_Reset_n=0 mid-sequence -> RLO=0, FC=1, Depth=0, flags 0, immediately (async).
//  2 FC chain: Src=8'b0000_0101; A sel0, A sel2, AN sel1 -> RLO=1 after each step; END; O sel1 -> RLO=0, FC=0.
//  3 Brackets: LD sel0 (1); A( ; LD sel1 (0); O sel2 (1) -> RLO=1
//      ) -> RLO=1&1=1, Depth 1->0
//      same sequence with X( -> RLO=0
//  4 Overflow: STACK_DEPTH=7 -> 8 pushes -> Depth=7, StkOvf=1 after 8th
//      7 pops -> Depth=0; extra pop -> StkUnf=1
//      ErrClr -> both flags 0
//  5 Collision: pop on empty with RLO_ErrClr=1 same cycle -> StkUnf=1; RLO_EN=0 cycles -> no change.
//  6 RLO_EDGE_EN: RLO 0,1,1,0 with FP sel3 each cycle -> RLO out 0,1,0,0
//      FN sequence -> pulse on 1->0
//      macro off -> FP leaves RLO/FC unchanged

Source files
------------

// File: rtl/rlo_pkg.sv
// Shared definitions for the RLO accumulator: opcodes, bracket-op encoding, stack entry.
// Optional edge ops (FP/FN) are enabled by defining RLO_EDGE_EN.
package rlo_pkg;

  localparam logic [4:0] RLO_OP_LD   = 5'h00;
  localparam logic [4:0] RLO_OP_LDN  = 5'h01;
  localparam logic [4:0] RLO_OP_A    = 5'h02;
  localparam logic [4:0] RLO_OP_AN   = 5'h03;
  localparam logic [4:0] RLO_OP_O    = 5'h04;
  localparam logic [4:0] RLO_OP_ON   = 5'h05;
  localparam logic [4:0] RLO_OP_X    = 5'h06;
  localparam logic [4:0] RLO_OP_XN   = 5'h07;
  localparam logic [4:0] RLO_OP_NOT  = 5'h08;
  localparam logic [4:0] RLO_OP_SET  = 5'h09;
  localparam logic [4:0] RLO_OP_CLR  = 5'h0A;
  localparam logic [4:0] RLO_OP_END  = 5'h0B;
  localparam logic [4:0] RLO_OP_APAR = 5'h0C;
  localparam logic [4:0] RLO_OP_OPAR = 5'h0D;
  localparam logic [4:0] RLO_OP_XPAR = 5'h0E;
  localparam logic [4:0] RLO_OP_CPAR = 5'h0F;
  localparam logic [4:0] RLO_OP_FP   = 5'h10;
  localparam logic [4:0] RLO_OP_FN   = 5'h11;

  typedef enum logic [1:0] {
    BR_AND = 2'd0,
    BR_OR  = 2'd1,
    BR_XOR = 2'd2
  } rlo_br_op_e;

  typedef struct packed {
    logic       rlo;
    logic       fc;
    rlo_br_op_e op;
  } rlo_stk_entry_t;

  // Combine the saved outer RLO with the inner bracket result on ')'.
  function automatic logic br_apply(rlo_br_op_e op, logic outer, logic inner);
    case (op)
      BR_AND:  br_apply = outer & inner;
      BR_OR:   br_apply = outer | inner;
      BR_XOR:  br_apply = outer ^ inner;
      default: br_apply = outer & inner;
    endcase
  endfunction

endpackage

// File: rtl/rlo_stack_unit_if.sv
// Operand/control bus between operand fetch and the RLO accumulator.
// Handshake: RLO_EN is a single-cycle execute strobe with no back-pressure; every op
// presented with RLO_EN=1 is accepted at that rising edge and its result is visible after it.
interface rlo_stack_unit_if #(
  parameter int NUM_SRC     = 8,
  parameter int STACK_DEPTH = 7
);
  localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int PTR_W = $clog2(STACK_DEPTH + 1);

  logic               RLO_EN;
  logic [4:0]         RLO_OPCode;
  logic [SEL_W-1:0]   RLO_SrcSel;
  logic [NUM_SRC-1:0] RLO_Src;
  logic               RLO_ErrClr;
  logic               RLO;
  logic               RLO_FC;
  logic [PTR_W-1:0]   RLO_Depth;
  logic               RLO_StkOvf;
  logic               RLO_StkUnf;

  modport master (
    output RLO_EN, RLO_OPCode, RLO_SrcSel, RLO_Src, RLO_ErrClr,
    input  RLO, RLO_FC, RLO_Depth, RLO_StkOvf, RLO_StkUnf
  );

  modport slave (
    input  RLO_EN, RLO_OPCode, RLO_SrcSel, RLO_Src, RLO_ErrClr,
    output RLO, RLO_FC, RLO_Depth, RLO_StkOvf, RLO_StkUnf
  );

endinterface

// File: rtl/rlo_stack.sv
// LIFO of bracket frames; the top entry is presented combinationally.
// The caller never asserts push and pop together and filters full/empty requests.
module rlo_stack
  import rlo_pkg::*;
#(
  parameter int STACK_DEPTH = 7
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               push,
  input  logic                               pop,
  input  rlo_stk_entry_t                     din,
  output rlo_stk_entry_t                     top,
  output logic                               full,
  output logic                               empty,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth
);
  localparam int PTR_W = $clog2(STACK_DEPTH + 1);

  rlo_stk_entry_t mem [STACK_DEPTH];

  assign full  = (depth == PTR_W'(STACK_DEPTH));
  assign empty = (depth == '0);
  assign top   = empty ? '0 : mem[depth - PTR_W'(1)];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) mem[i] <= '0;
    end else if (push && !full) begin
      mem[depth] <= din;
      depth      <= depth + PTR_W'(1);
    end else if (pop && !empty) begin
      depth      <= depth - PTR_W'(1);
    end
  end

endmodule

// File: rtl/rlo_stack_unit.sv
// Multi-source RLO accumulator with first-check flag and bracket nesting stack.
// Define RLO_EDGE_EN to add the per-source edge memory used by FP/FN.
module rlo_stack_unit
  import rlo_pkg::*;
#(
  parameter int NUM_SRC     = 8,
  parameter int STACK_DEPTH = 7
) (
  input  logic             CLK,
  input  logic             CPU_Reset_n,
  rlo_stack_unit_if.slave  bus
);
  localparam int PTR_W = $clog2(STACK_DEPTH + 1);

  logic           rlo_q, rlo_n;
  logic           fc_q, fc_n;
  logic           ovf_q, ovf_n, ovf_evt;
  logic           unf_q, unf_n, unf_evt;
  logic           src_ok, s;
  logic           push, pop;
  rlo_br_op_e     push_op;
  rlo_stk_entry_t push_entry, stk_top;
  logic           stk_full, stk_empty;
  logic [PTR_W-1:0] stk_depth;

  assign src_ok = (int'(bus.RLO_SrcSel) < NUM_SRC);
  assign s      = src_ok ? bus.RLO_Src[bus.RLO_SrcSel] : 1'b0;

`ifdef RLO_EDGE_EN
  logic [NUM_SRC-1:0] edge_mem;
  logic               edge_bit, edge_we;

  assign edge_bit = src_ok ? edge_mem[bus.RLO_SrcSel] : 1'b0;

  // Remembers the pre-op RLO per slot so FP/FN can see the previous scan's value.
  always_ff @(posedge CLK or negedge CPU_Reset_n) begin
    if (!CPU_Reset_n)  edge_mem <= '0;
    else if (edge_we)  edge_mem[bus.RLO_SrcSel] <= rlo_q;
  end
`endif

  always_comb begin
    push_entry.rlo = rlo_q;
    push_entry.fc  = fc_q;
    push_entry.op  = push_op;
  end

  rlo_stack #(.STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk   (CLK),
    .rst_n (CPU_Reset_n),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty),
    .depth (stk_depth)
  );

  always_comb begin
    rlo_n   = rlo_q;
    fc_n    = fc_q;
    push    = 1'b0;
    pop     = 1'b0;
    push_op = BR_AND;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
`ifdef RLO_EDGE_EN
    edge_we = 1'b0;
`endif
    if (bus.RLO_EN) begin
      case (bus.RLO_OPCode)
        RLO_OP_LD:  begin rlo_n = s;                               fc_n = 1'b0; end
        RLO_OP_LDN: begin rlo_n = ~s;                              fc_n = 1'b0; end
        RLO_OP_A:   begin rlo_n = fc_q ? s  : (rlo_q & s);         fc_n = 1'b0; end
        RLO_OP_AN:  begin rlo_n = fc_q ? ~s : (rlo_q & ~s);        fc_n = 1'b0; end
        RLO_OP_O:   begin rlo_n = fc_q ? s  : (rlo_q | s);         fc_n = 1'b0; end
        RLO_OP_ON:  begin rlo_n = fc_q ? ~s : (rlo_q | ~s);        fc_n = 1'b0; end
        RLO_OP_X:   begin rlo_n = fc_q ? s  : (rlo_q ^ s);         fc_n = 1'b0; end
        RLO_OP_XN:  begin rlo_n = fc_q ? ~s : ~(rlo_q ^ s);        fc_n = 1'b0; end
        RLO_OP_NOT: rlo_n = ~rlo_q;
        RLO_OP_SET: begin rlo_n = 1'b1;                            fc_n = 1'b0; end
        RLO_OP_CLR: begin rlo_n = 1'b0;                            fc_n = 1'b0; end
        RLO_OP_END: fc_n = 1'b1;
        RLO_OP_APAR, RLO_OP_OPAR, RLO_OP_XPAR: begin
          if (stk_full) begin
            ovf_evt = 1'b1;
          end else begin
            push = 1'b1;
            fc_n = 1'b1;
            push_op = (bus.RLO_OPCode == RLO_OP_OPAR) ? BR_OR :
                      (bus.RLO_OPCode == RLO_OP_XPAR) ? BR_XOR : BR_AND;
          end
        end
        RLO_OP_CPAR: begin
          if (stk_empty) begin
            unf_evt = 1'b1;
          end else begin
            pop  = 1'b1;
            fc_n = 1'b0;
            // A bracket opened on a first check just passes its inner result out.
            if (!stk_top.fc) rlo_n = br_apply(stk_top.op, stk_top.rlo, rlo_q);
          end
        end
`ifdef RLO_EDGE_EN
        RLO_OP_FP: if (src_ok) begin
          rlo_n = rlo_q & ~edge_bit;  fc_n = 1'b0;  edge_we = 1'b1;
        end
        RLO_OP_FN: if (src_ok) begin
          rlo_n = ~rlo_q & edge_bit;  fc_n = 1'b0;  edge_we = 1'b1;
        end
`endif
        default: ;
      endcase
    end
    // Clear acts independently of RLO_EN; a same-cycle error event keeps its flag set.
    ovf_n = (bus.RLO_ErrClr ? 1'b0 : ovf_q) | ovf_evt;
    unf_n = (bus.RLO_ErrClr ? 1'b0 : unf_q) | unf_evt;
  end

  always_ff @(posedge CLK or negedge CPU_Reset_n) begin
    if (!CPU_Reset_n) begin
      rlo_q <= 1'b0;
      fc_q  <= 1'b1;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      rlo_q <= rlo_n;
      fc_q  <= fc_n;
      ovf_q <= ovf_n;
      unf_q <= unf_n;
    end
  end

  assign bus.RLO        = rlo_q;
  assign bus.RLO_FC     = fc_q;
  assign bus.RLO_Depth  = stk_depth;
  assign bus.RLO_StkOvf = ovf_q;
  assign bus.RLO_StkUnf = unf_q;

endmodule

// File: tb/tb_rlo_stack_unit.sv
// Directed and randomized bench for rlo_stack_unit against a queue-based reference model.
// Build with RLO_EDGE_EN defined to exercise FP/FN; otherwise FP is checked as a NOP.
module tb_rlo_stack_unit;
  import rlo_pkg::*;

  localparam int NUM_SRC     = 8;
  localparam int STACK_DEPTH = 7;
  localparam int SEL_W       = 3;
  localparam int PTR_W       = 3;
  localparam int EXP_W       = 4 + PTR_W;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rlo_stack_unit_if #(.NUM_SRC(NUM_SRC), .STACK_DEPTH(STACK_DEPTH)) bus ();

  rlo_stack_unit #(.NUM_SRC(NUM_SRC), .STACK_DEPTH(STACK_DEPTH)) dut (
    .CLK         (clk),
    .CPU_Reset_n (rst_n),
    .bus         (bus)
  );

  int checks   = 0;
  int failures = 0;

  // reference model: bracket frames kept in a queue, depth is simply its size
  typedef struct {
    bit r;
    bit f;
    int kind;
  } frame_t;

  frame_t m_stk[$];
  bit     m_rlo, m_fc, m_ovf, m_unf;
  bit     m_edge[NUM_SRC];
  logic [EXP_W-1:0] exp_q[$];

  function automatic bit combine(int kind, bit a, bit b);
    case (kind)
      0:       return a & b;
      1:       return a | b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic model_reset();
    m_rlo = 1'b0;
    m_fc  = 1'b1;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_stk.delete();
    for (int i = 0; i < NUM_SRC; i++) m_edge[i] = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit en, input int op, input int sel,
                            input logic [7:0] src, input bit clr);
    bit s, b, ov, un, old;
    frame_t fr;
    s  = (sel < NUM_SRC) ? src[sel] : 1'b0;
    ov = 1'b0;
    un = 1'b0;
    if (en) begin
      case (op)
        0: begin m_rlo = s;  m_fc = 1'b0; end
        1: begin m_rlo = !s; m_fc = 1'b0; end
        2, 3, 4, 5, 6, 7: begin
          b = s ^ bit'(op % 2);
          m_rlo = m_fc ? b : combine((op - 2) / 2, m_rlo, b);
          m_fc  = 1'b0;
        end
        8:  m_rlo = !m_rlo;
        9:  begin m_rlo = 1'b1; m_fc = 1'b0; end
        10: begin m_rlo = 1'b0; m_fc = 1'b0; end
        11: m_fc = 1'b1;
        12, 13, 14: begin
          if (m_stk.size() == STACK_DEPTH) ov = 1'b1;
          else begin
            m_stk.push_back('{r: m_rlo, f: m_fc, kind: op - 12});
            m_fc = 1'b1;
          end
        end
        15: begin
          if (m_stk.size() == 0) un = 1'b1;
          else begin
            fr = m_stk.pop_back();
            if (!fr.f) m_rlo = combine(fr.kind, fr.r, m_rlo);
            m_fc = 1'b0;
          end
        end
`ifdef RLO_EDGE_EN
        16, 17: begin
          if (sel < NUM_SRC) begin
            old   = m_rlo;
            m_rlo = (op == 16) ? (old & !m_edge[sel]) : (!old & m_edge[sel]);
            m_edge[sel] = old;
            m_fc  = 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
    if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
    if (ov) m_ovf = 1'b1;
    if (un) m_unf = 1'b1;
    exp_q.push_back({m_rlo, m_fc, PTR_W'(m_stk.size()), m_ovf, m_unf});
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [EXP_W-1:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_noexp"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_rlo"},   32'(bus.RLO),        32'(e[EXP_W-1]));
      chk({tag, "_fc"},    32'(bus.RLO_FC),     32'(e[EXP_W-2]));
      chk({tag, "_depth"}, 32'(bus.RLO_Depth),  32'(e[PTR_W+1:2]));
      chk({tag, "_ovf"},   32'(bus.RLO_StkOvf), 32'(e[1]));
      chk({tag, "_unf"},   32'(bus.RLO_StkUnf), 32'(e[0]));
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_rlo"},   32'(bus.RLO),        32'd0);
    chk({tag, "_fc"},    32'(bus.RLO_FC),     32'd1);
    chk({tag, "_depth"}, 32'(bus.RLO_Depth),  32'd0);
    chk({tag, "_ovf"},   32'(bus.RLO_StkOvf), 32'd0);
    chk({tag, "_unf"},   32'(bus.RLO_StkUnf), 32'd0);
  endtask

  // driver tasks: called at posedge+1, result sampled at the next posedge+1
  task automatic exec(input string tag, input int op, input int sel,
                      input logic [7:0] src, input bit clr, input bit en);
    bus.RLO_EN     = en;
    bus.RLO_OPCode = op[4:0];
    bus.RLO_SrcSel = sel[SEL_W-1:0];
    bus.RLO_Src    = src;
    bus.RLO_ErrClr = clr;
    model_step(en, op, sel, src, clr);
    @(posedge clk);
    #1;
    bus.RLO_EN     = 1'b0;
    bus.RLO_ErrClr = 1'b0;
    check_state(tag);
  endtask

  task automatic op1(input string tag, input int op, input int sel, input logic [7:0] src);
    exec(tag, op, sel, src, 1'b0, 1'b1);
  endtask

  task automatic do_async_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_reset_values(tag);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] src;
    bit fp_in[4], fp_exp[4], fn_in[4], fn_exp[4];
    int r, op, sel;
    bit clr, en;

    bus.RLO_EN     = 1'b0;
    bus.RLO_OPCode = '0;
    bus.RLO_SrcSel = '0;
    bus.RLO_Src    = '0;
    bus.RLO_ErrClr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_values("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // asynchronous reset in the middle of a bracket
    op1("pre_ld", 0, 0, 8'h01);
    op1("pre_apar", 12, 0, 8'h01);
    op1("pre_apar2", 13, 0, 8'h01);
    do_async_reset("rst_async");

    // first-check chain
    src = 8'b0000_0101;
    op1("fc_a0", 2, 0, src);   chk("fc_a0_lit", 32'(bus.RLO), 32'd1);
    op1("fc_a2", 2, 2, src);   chk("fc_a2_lit", 32'(bus.RLO), 32'd1);
    op1("fc_an1", 3, 1, src);  chk("fc_an1_lit", 32'(bus.RLO), 32'd1);
    op1("fc_end", 11, 0, src); chk("fc_end_lit", 32'(bus.RLO_FC), 32'd1);
    op1("fc_o1", 4, 1, src);
    chk("fc_o1_rlo_lit", 32'(bus.RLO), 32'd0);
    chk("fc_o1_fc_lit", 32'(bus.RLO_FC), 32'd0);

    // brackets with AND and XOR
    op1("br_ld", 0, 0, src);
    op1("br_apar", 12, 0, src); chk("br_apar_depth_lit", 32'(bus.RLO_Depth), 32'd1);
    op1("br_ld1", 0, 1, src);
    op1("br_o2", 4, 2, src);    chk("br_o2_lit", 32'(bus.RLO), 32'd1);
    op1("br_close", 15, 0, src);
    chk("br_close_rlo_lit", 32'(bus.RLO), 32'd1);
    chk("br_close_depth_lit", 32'(bus.RLO_Depth), 32'd0);
    op1("bx_ld", 0, 0, src);
    op1("bx_xpar", 14, 0, src);
    op1("bx_ld1", 0, 1, src);
    op1("bx_o2", 4, 2, src);
    op1("bx_close", 15, 0, src); chk("bx_close_rlo_lit", 32'(bus.RLO), 32'd0);

    // stack overflow / underflow / clear
    do_async_reset("rst_stk");
    for (int i = 0; i < 8; i++) begin
      op1("ovf_push", 12 + (i % 3), 0, 8'($urandom));
      if (i == 6) chk("ovf_push7_flag_lit", 32'(bus.RLO_StkOvf), 32'd0);
    end
    chk("ovf_depth_lit", 32'(bus.RLO_Depth), 32'd7);
    chk("ovf_flag_lit", 32'(bus.RLO_StkOvf), 32'd1);
    for (int i = 0; i < 7; i++) op1("unf_pop", 15, 0, 8'($urandom));
    chk("unf_depth_lit", 32'(bus.RLO_Depth), 32'd0);
    chk("unf_pre_flag_lit", 32'(bus.RLO_StkUnf), 32'd0);
    op1("unf_extra", 15, 0, 8'h00);
    chk("unf_flag_lit", 32'(bus.RLO_StkUnf), 32'd1);
    exec("errclr", 18, 0, 8'h00, 1'b1, 1'b1);
    chk("errclr_ovf_lit", 32'(bus.RLO_StkOvf), 32'd0);
    chk("errclr_unf_lit", 32'(bus.RLO_StkUnf), 32'd0);

    // clear colliding with an underflow, then idle cycles hold everything
    exec("coll", 15, 0, 8'h00, 1'b1, 1'b1);
    chk("coll_unf_lit", 32'(bus.RLO_StkUnf), 32'd1);
    op1("hold_set", 9, 0, 8'h00);
    op1("hold_push", 13, 0, 8'h00);
    for (int i = 0; i < 4; i++)
      exec("hold", $urandom_range(0, 17), $urandom_range(0, 7), 8'($urandom), 1'b0, 1'b0);

`ifdef RLO_EDGE_EN
    do_async_reset("rst_edge");
    fp_in  = '{1'b0, 1'b1, 1'b1, 1'b0};
    fp_exp = '{1'b0, 1'b1, 1'b0, 1'b0};
    fn_in  = '{1'b1, 1'b1, 1'b0, 1'b0};
    fn_exp = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      op1("fp_ld", 0, 0, {7'd0, fp_in[i]});
      op1("fp", 16, 3, 8'($urandom));
      chk("fp_lit", 32'(bus.RLO), 32'(fp_exp[i]));
    end
    for (int i = 0; i < 4; i++) begin
      op1("fn_ld", 0, 0, {7'd0, fn_in[i]});
      op1("fn", 17, 3, 8'($urandom));
      chk("fn_lit", 32'(bus.RLO), 32'(fn_exp[i]));
    end
`else
    op1("fpnop_ld", 0, 0, 8'h01);
    op1("fpnop_end", 11, 0, 8'h01);
    op1("fpnop", 16, 3, 8'hFF);
    chk("fpnop_rlo_lit", 32'(bus.RLO), 32'd1);
    chk("fpnop_fc_lit", 32'(bus.RLO_FC), 32'd1);
`endif

    // randomized run against the model
    do_async_reset("rst_rand");
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      op = $urandom_range(0, 11);
      else if (r < 80) op = $urandom_range(12, 14);
      else if (r < 95) op = 15;
      else             op = $urandom_range(16, 31);
      sel = $urandom_range(0, 7);
      clr = ($urandom_range(0, 19) == 0);
      en  = ($urandom_range(0, 9) != 0);
      exec("rand", op, sel, 8'($urandom), clr, en);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
